// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier scheduler.
package fp_mul_pkg;

  localparam int EXP_W    = 8;
  localparam int FRC_W    = 23;
  localparam int FP_W     = 1 + EXP_W + FRC_W;
  localparam int ID_W_MAX = 3;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rmode_e;

  // Id is sized for the largest supported requester count; narrower configs zero-extend.
  typedef struct packed {
    logic [FP_W-1:0]     z;
    logic                ovrf;
    logic                udrf;
    logic [ID_W_MAX-1:0] id;
  } mul_rsp_t;

endpackage

// File: rtl/fp_mul_rsp_fifo.sv
// Response FIFO of mul_rsp_t; head is presented combinationally, pointers carry a wrap bit.
module fp_mul_rsp_fifo
  import fp_mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  mul_rsp_t               push_data_i,
  input  logic                   pop_i,
  output mul_rsp_t               head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  mul_rsp_t    mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop_i && !empty_o;
  // A write into a full FIFO is only taken when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one FP32 multiplier among NREQ requesters.
// Define FP_MUL_SCHED_PERF_EN to build the issue/stall performance counters.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int LAT        = 2,
  parameter int RBUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_x,
  input  logic [NREQ*32-1:0]      req_y,
  input  logic [NREQ*3-1:0]       req_rmode,
  output logic [31:0]             mul_x,
  output logic [31:0]             mul_y,
  output logic [2:0]              mul_rmode,
  output logic                    mul_valid,
  input  logic [31:0]             mul_z,
  input  logic                    mul_ovrf,
  input  logic                    mul_udrf,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_z,
  output logic                    rsp_ovrf,
  output logic                    rsp_udrf,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_stall
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(RBUF_DEPTH) + 1;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  win;
  logic            win_found, credit_ok, accept;
  logic [CW-1:0]   cnt;

  logic            issue_vld_q;
  logic [IDW-1:0]  issue_id_q;
  logic [FP_W-1:0] mul_x_q, mul_y_q;
  rmode_e          mul_rmode_q;

  logic [LAT-1:0]  pipe_vld_q;
  logic [IDW-1:0]  pipe_id_q [LAT];

  mul_rsp_t        fifo_wdata, fifo_head;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win       = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
  end

  // Every operation between accept and pop holds one credit, so the FIFO can never overflow.
  always_comb begin
    cnt = fifo_count + CW'(issue_vld_q);
    for (int k = 0; k < LAT; k++) cnt = cnt + CW'(pipe_vld_q[k]);
  end

  assign credit_ok = (cnt < CW'(RBUF_DEPTH)) && !fifo_full;
  assign accept    = win_found && credit_ok;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (win == IDW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      issue_vld_q <= 1'b0;
      issue_id_q  <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_rmode_q <= RNE;
    end else begin
      issue_vld_q <= accept;
      if (accept) begin
        rr_ptr_q    <= rr_ptr_d;
        issue_id_q  <= win;
        mul_x_q     <= req_x[int'(win)*FP_W +: FP_W];
        mul_y_q     <= req_y[int'(win)*FP_W +: FP_W];
        mul_rmode_q <= rmode_e'(req_rmode[int'(win)*3 +: 3]);
      end
    end
  end

  assign mul_valid = issue_vld_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_rmode = mul_rmode_q;

  // Stage LAT-1 lines up with the multiplier presenting the result of that operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < LAT; k++) pipe_id_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= issue_vld_q;
      pipe_id_q[0]  <= issue_id_q;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.z    = mul_z;
    fifo_wdata.ovrf = mul_ovrf;
    fifo_wdata.udrf = mul_udrf;
    fifo_wdata.id   = ID_W_MAX'(pipe_id_q[LAT-1]);
  end

  fp_mul_rsp_fifo #(.DEPTH(RBUF_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pipe_vld_q[LAT-1]),
    .push_data_i(fifo_wdata),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_z     = fifo_empty ? '0   : fifo_head.z;
  assign rsp_ovrf  = fifo_empty ? 1'b0 : fifo_head.ovrf;
  assign rsp_udrf  = fifo_empty ? 1'b0 : fifo_head.udrf;
  assign rsp_id    = fifo_empty ? '0   : fifo_head.id[IDW-1:0];
  assign busy      = (cnt != '0);

`ifdef FP_MUL_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && perf_issue_q != '1) perf_issue_q <= perf_issue_q + 32'd1;
      if ((|req_valid) && !accept && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_issue = '0;
  assign perf_stall = '0;
`endif

endmodule
